// File: rtl/i2c_codec_responder.sv
// WM8731-style I2C write-only responder: ACKs 3-byte register writes
// and keeps a 16x9 register file, oversampled on the system clock.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_active,
    output logic       o_busy,
    output logic       o_nack
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_REG,
        S_ACK_REG, S_DATA, S_ACK_DATA, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [6:0] addr_q, addr_d;
    logic       d8_q, d8_d;
    logic [7:0] dat_q, dat_d;
    logic       oe_q, oe_d;
    logic       wr_valid_q, wr_valid_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic       nack_q, nack_d;
    logic [8:0] rf_q [16];
    logic [8:0] rf_d [16];

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_ev   = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev    = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        d8_d       = d8_q;
        dat_d      = dat_q;
        oe_d       = oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        nack_d     = 1'b0;
        rf_d       = rf_q;
        if (start_ev) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_ev) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR, S_REG, S_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        sh_d  = {sh_q[6:0], sda_s};
                        cnt_d = cnt_q + 4'd1;
                    end
                    // Byte is complete once its 8th clock has fallen.
                    if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        oe_d  = 1'b1;
                        if (state_q == S_ADDR) begin
                            if (sh_q[7:1] == DEV_ADDR && !sh_q[0]) begin
                                state_d = S_ACK_ADDR;
                            end else begin
                                state_d = S_IGNORE;
                                oe_d    = 1'b0;
                                nack_d  = 1'b1;
                            end
                        end else if (state_q == S_REG) begin
                            addr_d  = sh_q[7:1];
                            d8_d    = sh_q[0];
                            state_d = S_ACK_REG;
                        end else begin
                            dat_d   = sh_q;
                            state_d = S_ACK_DATA;
                        end
                    end
                end
                S_ACK_ADDR, S_ACK_REG, S_ACK_DATA: begin
                    if (scl_fall) begin
                        oe_d = 1'b0;
                        if (state_q == S_ACK_ADDR) begin
                            state_d = S_REG;
                        end else if (state_q == S_ACK_REG) begin
                            state_d = S_DATA;
                        end else begin
                            state_d    = S_IGNORE;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = {d8_q, dat_q};
                            if (addr_q < 7'd15) begin
                                rf_d[addr_q[3:0]] = {d8_q, dat_q};
                            end else if (addr_q == 7'd15) begin
                                for (int i = 0; i < 16; i++) rf_d[i] = '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            d8_q       <= 1'b0;
            dat_q      <= '0;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            nack_q     <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            d8_q       <= d8_d;
            dat_q      <= dat_d;
            oe_q       <= oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            nack_q     <= nack_d;
            rf_q       <= rf_d;
        end
    end

    assign o_sda_oe   = oe_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_rd_data  = rf_q[i_rd_addr];
    assign o_active   = rf_q[9][0];
    assign o_busy     = (state_q != S_IDLE);
    assign o_nack     = nack_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C initiator with a
// transaction-level model of the codec register file.
module tb_i2c_codec_responder;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       oe, wr_valid, active, busy, nack;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr = '0;

    int checks = 0;
    int errors = 0;
    int nack_cnt = 0;
    int nack_exp = 0;
    int oe_bad = 0;
    logic [8:0]  rf_m [16];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    assign sda_bus = m_sda & ~oe;

    i2c_codec_responder dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_scl     (m_scl),
        .i_sda     (sda_bus),
        .o_sda_oe  (oe),
        .o_wr_valid(wr_valid),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .o_active  (active),
        .o_busy    (busy),
        .o_nack    (nack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_valid) got_q.push_back({wr_addr, wr_data});
        if (rst_n && nack) nack_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic byte_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(Q);
            m_scl = 1'b1; tick(Q);
            if (oe) oe_bad++;
            tick(Q);
            m_scl = 1'b0; tick(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        byte_bits(b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        ack = ~sda_bus;
        tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic model_commit(input logic [6:0] a, input logic [8:0] d);
        exp_q.push_back({a, d});
        if (a < 7'd15) rf_m[a[3:0]] = d;
        else if (a == 7'd15) foreach (rf_m[i]) rf_m[i] = '0;
    endtask

    task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input int n, input bit do_stop);
        logic [7:0] bs [4];
        logic ack;
        bit ok;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        ok = (b0 == 8'h34);
        if (!ok) nack_exp++;
        oe_bad = 0;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            write_byte(bs[i], ack);
            check($sformatf("ack%0d", i), ack, ok && i < 3);
            if (ok && i == 2) model_commit(b1[7:1], {b1[0], b2});
        end
        check("oe_outside_ack", oe_bad, 0);
        if (do_stop) begin
            i2c_stop();
            tick(8);
            check("busy_idle", busy, 0);
        end
    endtask

    task automatic check_commits();
        logic [15:0] g, e;
        tick(8);
        check("ncommit", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check("commit", g, e);
        end
        got_q.delete();
        exp_q.delete();
        check("nack_cnt", nack_cnt, nack_exp);
        check("active", active, rf_m[9][0]);
    endtask

    task automatic readback();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("rd%0d", i), rd_data, rf_m[i]);
        end
    endtask

    initial begin
        logic [7:0] b0, b1;
        int n;
        foreach (rf_m[i]) rf_m[i] = '0;
        tick(3);
        check("rst_oe", oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_active", active, 0);
        check("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        tick(5);

        run_txn(8'h34, 8'h08, 8'h15, 8'h00, 3, 1);
        check_commits();
        readback();

        run_txn(8'h34, 8'h0A, 8'h00, 8'h00, 3, 1);
        run_txn(8'h34, 8'h0C, 8'h00, 8'h00, 3, 1);
        run_txn(8'h34, 8'h0E, 8'h42, 8'h00, 3, 1);
        run_txn(8'h34, 8'h10, 8'h19, 8'h00, 3, 1);
        check("active_pre", active, 0);
        run_txn(8'h34, 8'h12, 8'h01, 8'h00, 3, 1);
        check_commits();
        readback();

        run_txn(8'h34, 8'h1E, 8'h00, 8'h00, 3, 1);
        check_commits();
        readback();

        run_txn(8'h36, 8'h12, 8'h01, 8'h00, 3, 1);
        check_commits();

        run_txn(8'h34, 8'h12, 8'h00, 8'h00, 2, 0);
        run_txn(8'h34, 8'h0E, 8'h42, 8'h00, 3, 1);
        check_commits();

        // Pull reset while the responder is driving the REG-byte ACK.
        i2c_start();
        write_byte(8'h34, b0[0]);
        byte_bits(8'h08);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(2);
        check("oe_in_ack", oe, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_oe", oe, 0);
        check("rst_mid_busy", busy, 0);
        foreach (rf_m[i]) rf_m[i] = '0;
        readback();
        tick(3);
        rst_n = 1'b1;
        tick(5);
        run_txn(8'h34, 8'h12, 8'h01, 8'h00, 3, 1);
        check_commits();

        for (int t = 0; t < 40; t++) begin
            b0 = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h34;
            b1 = ($urandom_range(1) == 0) ? 8'($urandom_range(31)) : 8'($urandom);
            n  = $urandom_range(1, 4);
            run_txn(b0, b1, 8'($urandom), 8'($urandom), n,
                    (t == 39) || ($urandom_range(3) != 0));
            if ($urandom_range(3) == 0) check_commits();
        end
        i2c_stop();
        check_commits();
        readback();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
